pipe_reg_elastic: RTL and testbench



---
 rtl/pipe_reg_elastic.sv | 118 +++++++++++
 tb/tb_pipe_reg_elastic.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic
//   Elastic chain of DEPTH load-enabled registers, WIDTH bits each, with a
//   valid/ready handshake on both ends. Each stage has its own valid bit, so
//   bubbles collapse under backpressure. The block also provides a
//   synchronous flush and a registered occupancy count.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset; clears valids, loads RESET_VALUE
//   flush      synchronous clear of all valid bits; data registers keep value
//   in_valid   upstream presents in_data
//   in_data    upstream word
//   in_ready   chain accepts in_data this cycle (combinational from out_ready)
//   out_valid  last stage holds a valid word
//   out_data   last stage data
//   out_ready  downstream consumes out_data this cycle
//   count      number of valid stages, 0..DEPTH (registered)

module pipe_reg_elastic #(
  parameter int              WIDTH       = 32,
  parameter int              DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  // rdy[i] = !v[i] | rdy[i+1] with rdy[DEPTH] = out_ready, unrolled so each
  // stage is out_ready OR'd with "some stage at or after i is empty". This
  // avoids a self-referencing vector while keeping the same function.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic r;
      r = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        r = r | ~v_q[j];
      end
      rdy[i] = r;
    end
  end

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = data_q[i-1];
    end
  end

  always_comb begin
    v_d     = v_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    if (flush) begin
      // Valids drop, data registers are left alone; nothing is accepted.
      v_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = src_v[i];
          if (src_v[i]) begin
            data_d[i] = src_d[i];
          end
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
      v_q     <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic with DEPTH=3, WIDTH=32,
// RESET_VALUE=32'hDEADBEEF. Inputs change 1ns after a rising edge, and
// outputs are sampled at that same point, before the next edge.

module tb_pipe_reg_elastic;

  localparam int              WIDTH = 32;
  localparam int              DEPTH = 3;
  localparam logic [31:0]     RV    = 32'hDEAD_BEEF;
  localparam int              CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  int total = 0;
  int bad   = 0;

  pipe_reg_elastic #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'd7; out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       RV);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("rst_nothing_accepted", 32'(count), 32'd0);
    chk("rst_out_data_hold",    out_data,   RV);

    // Streaming 1..4, out_ready high
    out_ready = 1'b1;
    for (int n = 0; n < 7; n++) begin
      in_valid = (n < 4);
      in_data  = 32'(n + 1);
      step();
      if (n < 2) begin
        chk("stream_latency_valid", 32'(out_valid), 32'd0);
      end else if (n < 6) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data",  out_data,       32'(n - 1));
      end else begin
        chk("stream_drained_valid", 32'(out_valid), 32'd0);
        chk("stream_drained_count", 32'(count),     32'd0);
      end
      if (n == 2 || n == 3) chk("stream_count", 32'(count), 32'd3);
    end

    // Backpressure: 10,11,12 fill the chain, 13 waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_data = 32'(10 + n);
      step();
    end
    chk("bp_count_full", 32'(count), 32'd3);
    in_data = 32'd13;
    settle();
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("bp_stall_count", 32'(count),   32'd3);
    chk("bp_stall_data",  out_data,     32'd10);
    out_ready = 1'b1;
    settle();
    chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_11",  out_data,   32'd11);
    chk("bp_count_13_in", 32'(count), 32'd3);
    step();
    chk("bp_out_12", out_data, 32'd12);
    step();
    chk("bp_out_13", out_data, 32'd13);
    chk("bp_out_13_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Bubble collapse: 5, idle, 6 with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd5; step();
    in_valid = 1'b0;                  step();
    in_valid = 1'b1; in_data = 32'd6; step();
    in_valid = 1'b0;                  step();
    chk("bub_count",    32'(count),    32'd2);
    chk("bub_out_5",    out_data,      32'd5);
    chk("bub_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bub_next_valid", 32'(out_valid), 32'd1);
    chk("bub_next_6",     out_data,       32'd6);
    step();
    chk("bub_empty", 32'(out_valid), 32'd0);

    // Flush with a word offered and in_ready high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_data = 32'(21 + n);
      step();
    end
    chk("fl_full", 32'(count), 32'd3);
    out_ready = 1'b1; flush = 1'b1; in_data = 32'd99;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count",     32'(count),     32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("fl_no_99", 32'(out_valid), 32'd0);
    end

    // Reset in mid-stream
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd31; step();
    in_data = 32'd32; step();
    rst = 1'b1; in_data = 32'd33; step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_data",  out_data,       RV);
    chk("mrst_count", 32'(count),     32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'd40; step();
    in_valid = 1'b0;
    chk("mrst_lat1", 32'(out_valid), 32'd0);
    step();
    chk("mrst_lat2", 32'(out_valid), 32'd0);
    step();
    chk("mrst_40_valid", 32'(out_valid), 32'd1);
    chk("mrst_40_data",  out_data,       32'd40);
    step();
    chk("mrst_done", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
